paddle_input_array: RTL

Parametrised N-player paddle input block that replaces the fixed two-player debounce-plus-button paddle path in the Pong design. It synchronises and debounces per-player up/down buttons, converts held buttons into rate-limited paddle motion with optional hold-to-accelerate, and clamps each paddle to the playfield for the current bat size. It runs on the system clock and feeds paddle Y positions to the game controller and video encoder.

---
 rtl/paddle_input_array.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/paddle_input_array.sv
// N-player paddle input block: per-button sync/debounce, tick-paced paddle motion, playfield clamp.
// Define PADDLE_ACCEL_EN to build the hold-to-accelerate SLOW/FAST stage and its run counter.
module paddle_input_array #(
  parameter int N_PLAYERS   = 2,
  parameter int Y_W         = 11,
  parameter int SCREEN_H    = 480,
  parameter int BAT_SMALL   = 48,
  parameter int BAT_LARGE   = 96,
  parameter int CENTER_Y    = 192,
  parameter int DEB_CYCLES  = 50000,
  parameter int TICK_DIV    = 400000,
  parameter int STEP        = 4,
  parameter int ACCEL_TICKS = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     bat_size,
  input  logic [N_PLAYERS-1:0]     btn_up,
  input  logic [N_PLAYERS-1:0]     btn_dn,
  output logic [N_PLAYERS*Y_W-1:0] paddle_y,
  output logic [2*N_PLAYERS-1:0]   btn_state,
  output logic                     tick
);

  localparam int NB    = 2 * N_PLAYERS;
  localparam int Y_W1  = Y_W + 1;
  localparam int DEB_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam int DIV_W = $clog2(TICK_DIV);

  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
  localparam logic [Y_W1-1:0]  YMAX_S   = Y_W1'(SCREEN_H - BAT_SMALL);
  localparam logic [Y_W1-1:0]  YMAX_L   = Y_W1'(SCREEN_H - BAT_LARGE);
  localparam logic [Y_W1-1:0]  STEP_1   = Y_W1'(STEP);
  localparam logic [Y_W1-1:0]  STEP_2   = Y_W1'(2 * STEP);
  localparam logic [Y_W-1:0]   Y_RESET  = Y_W'(CENTER_Y);

  if (N_PLAYERS < 1 || N_PLAYERS > 8 || DEB_CYCLES < 1 || TICK_DIV < 2 ||
      ACCEL_TICKS < 0 || CENTER_Y > SCREEN_H - BAT_LARGE) begin : g_param_check
    $error("paddle_input_array: illegal parameter set");
  end

`ifdef PADDLE_ACCEL_EN
  localparam int RUN_W = (ACCEL_TICKS > 1) ? $clog2(ACCEL_TICKS + 1) : 1;
  localparam logic [RUN_W-1:0] RUN_LIM = RUN_W'(ACCEL_TICKS);
  typedef enum logic [1:0] {IDLE, SLOW, FAST} state_t;
`else
  typedef enum logic {IDLE, SLOW} state_t;
`endif

  logic [NB-1:0]                 sync1_q, sync1_d;
  logic [NB-1:0]                 sync2_q, sync2_d;
  logic [NB-1:0]                 deb_q, deb_d;
  logic [NB-1:0][DEB_W-1:0]      cnt_q, cnt_d;
  logic [DIV_W-1:0]              div_q, div_d;
  logic [N_PLAYERS-1:0][Y_W-1:0] y_q, y_d;
  logic [Y_W1-1:0]               ymax;
  state_t                        state_q [N_PLAYERS];
  state_t                        state_d [N_PLAYERS];
`ifdef PADDLE_ACCEL_EN
  logic [N_PLAYERS-1:0]            dir_q, dir_d;
  logic [N_PLAYERS-1:0][RUN_W-1:0] run_q, run_d;
`endif

  // Button bit 2i is player i up, bit 2i+1 is player i down, matching btn_state.
  always_comb begin
    sync1_d = '0;
    for (int i = 0; i < N_PLAYERS; i++) begin
      sync1_d[2*i]   = btn_up[i];
      sync1_d[2*i+1] = btn_dn[i];
    end
    sync2_d = sync1_q;
  end

  always_comb begin
    deb_d = deb_q;
    for (int b = 0; b < NB; b++) begin
      cnt_d[b] = '0;
      if (sync2_q[b] != deb_q[b]) begin
        if (cnt_q[b] == DEB_LAST) deb_d[b] = sync2_q[b];
        else                      cnt_d[b] = cnt_q[b] + DEB_W'(1);
      end
    end
  end

  always_comb begin
    div_d = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
    ymax  = bat_size ? YMAX_L : YMAX_S;
  end

  assign tick = (div_q == DIV_LAST);

  always_comb begin : p_chan
    logic            up, dn, mv, fast;
    logic [Y_W1-1:0] y_ext, stp, y_mv;
    for (int i = 0; i < N_PLAYERS; i++) begin
      state_d[i] = state_q[i];
      up         = deb_q[2*i];
      dn         = deb_q[2*i+1];
      mv         = 1'b0;
      fast       = 1'b0;
`ifdef PADDLE_ACCEL_EN
      dir_d[i]   = dir_q[i];
      run_d[i]   = run_q[i];
`endif
      if (!en) begin
        state_d[i] = IDLE;
`ifdef PADDLE_ACCEL_EN
        run_d[i]   = '0;
`endif
      end else if (tick) begin
        if (up == dn) begin
          state_d[i] = IDLE;
`ifdef PADDLE_ACCEL_EN
          run_d[i]   = '0;
`endif
        end else begin
          mv = 1'b1;
`ifdef PADDLE_ACCEL_EN
          dir_d[i] = dn;
          // A fresh start or a reversal restarts the run at one slow move.
          if (state_q[i] == IDLE || dir_q[i] != dn) begin
            run_d[i]   = RUN_W'(1);
            state_d[i] = (RUN_W'(1) >= RUN_LIM) ? FAST : SLOW;
          end else if (state_q[i] == SLOW) begin
            run_d[i]   = run_q[i] + RUN_W'(1);
            state_d[i] = (run_d[i] >= RUN_LIM) ? FAST : SLOW;
          end else begin
            fast = 1'b1;
          end
`else
          state_d[i] = SLOW;
`endif
        end
      end

      y_ext = {1'b0, y_q[i]};
      stp   = fast ? STEP_2 : STEP_1;
      if (dn) y_mv = (y_ext + stp > ymax) ? ymax : y_ext + stp;
      else    y_mv = (y_ext < stp) ? '0 : y_ext - stp;

      // The bat-size clamp wins over any move in the same cycle.
      if (y_ext > ymax) y_d[i] = ymax[Y_W-1:0];
      else if (mv)      y_d[i] = y_mv[Y_W-1:0];
      else              y_d[i] = y_q[i];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      deb_q   <= '0;
      cnt_q   <= '0;
      div_q   <= '0;
      y_q     <= {N_PLAYERS{Y_RESET}};
      for (int i = 0; i < N_PLAYERS; i++) state_q[i] <= IDLE;
`ifdef PADDLE_ACCEL_EN
      dir_q   <= '0;
      run_q   <= '0;
`endif
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      deb_q   <= deb_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      y_q     <= y_d;
      for (int i = 0; i < N_PLAYERS; i++) state_q[i] <= state_d[i];
`ifdef PADDLE_ACCEL_EN
      dir_q   <= dir_d;
      run_q   <= run_d;
`endif
    end
  end

  assign paddle_y  = y_q;
  assign btn_state = deb_q;

endmodule
